// File: rtl/adv_timer_cmd_sched.sv
// Timer command scheduler: round-robin requester arbitration into a small FIFO,
// then one-cycle start/stop/rst/update/arm pulses to masked timers after a per-command delay.
module adv_timer_cmd_sched #(
    parameter int unsigned N_TIMERS   = 4,
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DLY_BITS   = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ*3-1:0]            req_cmd_i,
    input  logic [N_REQ*N_TIMERS-1:0]     req_mask_i,
    input  logic [N_REQ*DLY_BITS-1:0]     req_dly_i,
    input  logic                          abort_i,
    output logic [N_TIMERS-1:0]           timer_start_o,
    output logic [N_TIMERS-1:0]           timer_stop_o,
    output logic [N_TIMERS-1:0]           timer_rst_o,
    output logic [N_TIMERS-1:0]           timer_update_o,
    output logic [N_TIMERS-1:0]           timer_arm_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          busy_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] CMD_START  = 3'd1;
    localparam logic [2:0] CMD_STOP   = 3'd2;
    localparam logic [2:0] CMD_RST    = 3'd3;
    localparam logic [2:0] CMD_UPDATE = 3'd4;
    localparam logic [2:0] CMD_ARM    = 3'd5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]          state, state_nxt;
    logic [RR_W-1:0]     rr_ptr, grant_idx, cand;
    logic                grant, pop, fire;
    logic [2:0]          push_cmd, fire_cmd, exec_cmd;
    logic [N_TIMERS-1:0] push_mask, fire_mask, exec_mask;
    logic [DLY_BITS-1:0] push_dly, dly_cnt, dly_nxt;
    logic [N_TIMERS-1:0] start_nxt, stop_nxt, rst_nxt, update_nxt, arm_nxt;

    logic [2:0]          cmd_q  [FIFO_DEPTH];
    logic [N_TIMERS-1:0] mask_q [FIFO_DEPTH];
    logic [DLY_BITS-1:0] dly_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;

    // Round-robin grant; the loop runs downward so the requester closest to rr_ptr wins.
    always_comb begin
        grant       = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        req_ready_o = '0;
        push_cmd    = '0;
        push_mask   = '0;
        push_dly    = '0;
        if (rstn_i && !abort_i && fifo_cnt_o != CNT_W'(FIFO_DEPTH)) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = RR_W'((int'(rr_ptr) + k) % N_REQ);
                if (req_valid_i[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && grant_idx == RR_W'(i)) begin
                req_ready_o[i] = 1'b1;
                push_cmd       = req_cmd_i[3*i +: 3];
                push_mask      = req_mask_i[N_TIMERS*i +: N_TIMERS];
                push_dly       = req_dly_i[DLY_BITS*i +: DLY_BITS];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Queue storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            cmd_q[wr_ptr]  <= push_cmd;
            mask_q[wr_ptr] <= push_mask;
            dly_q[wr_ptr]  <= push_dly;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i || abort_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt_o <= fifo_cnt_o + CNT_W'(grant) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state plus pulse decode; pulses are computed for the cycle that will be ISSUE.
    always_comb begin
        state_nxt  = state;
        dly_nxt    = dly_cnt;
        pop        = 1'b0;
        fire       = 1'b0;
        fire_cmd   = exec_cmd;
        fire_mask  = exec_mask;
        start_nxt  = '0;
        stop_nxt   = '0;
        rst_nxt    = '0;
        update_nxt = '0;
        arm_nxt    = '0;
        case (state)
            S_IDLE: begin
                if (fifo_cnt_o != '0) begin
                    pop = 1'b1;
                    if (dly_q[rd_ptr] == '0) begin
                        state_nxt = S_ISSUE;
                        fire      = 1'b1;
                        fire_cmd  = cmd_q[rd_ptr];
                        fire_mask = mask_q[rd_ptr];
                    end else begin
                        state_nxt = S_WAIT;
                        dly_nxt   = dly_q[rd_ptr];
                    end
                end
            end
            S_WAIT: begin
                dly_nxt = dly_cnt - 1'b1;
                if (dly_cnt == DLY_BITS'(1)) begin
                    state_nxt = S_ISSUE;
                    fire      = 1'b1;
                end
            end
            S_ISSUE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_i) begin
            state_nxt = S_IDLE;
            dly_nxt   = '0;
            pop       = 1'b0;
            fire      = 1'b0;
        end
        if (fire) begin
            case (fire_cmd)
                CMD_START:  start_nxt  = fire_mask;
                CMD_STOP:   stop_nxt   = fire_mask;
                CMD_RST:    rst_nxt    = fire_mask;
                CMD_UPDATE: update_nxt = fire_mask;
                CMD_ARM:    arm_nxt    = fire_mask;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dly_cnt        <= '0;
            exec_cmd       <= '0;
            exec_mask      <= '0;
            timer_start_o  <= '0;
            timer_stop_o   <= '0;
            timer_rst_o    <= '0;
            timer_update_o <= '0;
            timer_arm_o    <= '0;
        end else begin
            dly_cnt <= dly_nxt;
            if (pop) begin
                exec_cmd  <= cmd_q[rd_ptr];
                exec_mask <= mask_q[rd_ptr];
            end
            timer_start_o  <= start_nxt;
            timer_stop_o   <= stop_nxt;
            timer_rst_o    <= rst_nxt;
            timer_update_o <= update_nxt;
            timer_arm_o    <= arm_nxt;
        end
    end

    assign busy_o = (state != S_IDLE) || (fifo_cnt_o != '0);

endmodule

// File: tb/tb_adv_timer_cmd_sched.sv
// Bench for adv_timer_cmd_sched: directed scenarios plus random traffic, checked every
// cycle against a queue-and-timestamp reference model.
module tb_adv_timer_cmd_sched;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [2:0] cmd  [2];
    logic [3:0] mask [2];
    logic [7:0] dly  [2];
    logic       abort;
    logic [3:0] t_start, t_stop, t_rst, t_update, t_arm;
    logic [2:0] fifo_cnt;
    logic       busy;

    // stimulus staged here, applied at the next falling edge
    logic       st_rstn, st_abort;
    logic [1:0] st_valid;
    logic [2:0] st_cmd  [2];
    logic [3:0] st_mask [2];
    logic [7:0] st_dly  [2];

    adv_timer_cmd_sched dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (valid),
        .req_ready_o    (ready),
        .req_cmd_i      ({cmd[1], cmd[0]}),
        .req_mask_i     ({mask[1], mask[0]}),
        .req_dly_i      ({dly[1], dly[0]}),
        .abort_i        (abort),
        .timer_start_o  (t_start),
        .timer_stop_o   (t_stop),
        .timer_rst_o    (t_rst),
        .timer_update_o (t_update),
        .timer_arm_o    (t_arm),
        .fifo_cnt_o     (fifo_cnt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cmd;
        logic [3:0] mask;
        logic [7:0] dly;
    } entry_t;

    entry_t     q[$];
    int         rr = 0;
    bit         have_exec = 0;
    int         pulse_cycle = 0;
    logic [2:0] ex_cmd = '0;
    logic [3:0] ex_mask = '0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] c, input logic [3:0] m, input logic [7:0] d);
        st_cmd[i]  = c;
        st_mask[i] = m;
        st_dly[i]  = d;
    endtask

    // One clock cycle: apply stimulus, compare all outputs with the model, advance the model.
    task automatic step();
        logic [1:0] exp_ready;
        logic [3:0] ev [5];
        int         gidx;
        bit         active;
        entry_t     e;
        @(negedge clk);
        rstn  = st_rstn;
        abort = st_abort;
        valid = st_valid;
        for (int i = 0; i < 2; i++) begin
            cmd[i]  = st_cmd[i];
            mask[i] = st_mask[i];
            dly[i]  = st_dly[i];
        end
        #1;
        exp_ready = '0;
        gidx      = 0;
        if (rstn && !abort && q.size() < DEPTH) begin
            for (int k = 0; k < 2; k++) begin
                int j;
                j = (rr + k) % 2;
                if (valid[j] && exp_ready == 2'b00) begin
                    exp_ready[j] = 1'b1;
                    gidx = j;
                end
            end
        end
        active = have_exec && (cyc <= pulse_cycle);
        for (int i = 0; i < 5; i++)
            ev[i] = (have_exec && pulse_cycle == cyc && ex_cmd == 3'(i + 1)) ? ex_mask : 4'h0;
        chk("ready",    32'(ready),    32'(exp_ready));
        chk("start",    32'(t_start),  32'(ev[0]));
        chk("stop",     32'(t_stop),   32'(ev[1]));
        chk("rst",      32'(t_rst),    32'(ev[2]));
        chk("update",   32'(t_update), 32'(ev[3]));
        chk("arm",      32'(t_arm),    32'(ev[4]));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
        chk("busy",     32'(busy),     32'(active || q.size() != 0));
        if (!rstn) begin
            q.delete();
            rr = 0;
            have_exec = 0;
        end else if (abort) begin
            q.delete();
            have_exec = 0;
        end else begin
            if (!active && q.size() > 0) begin
                e = q.pop_front();
                have_exec   = 1;
                ex_cmd      = e.cmd;
                ex_mask     = e.mask;
                pulse_cycle = cyc + 1 + int'(e.dly);
            end
            if (exp_ready != 2'b00) begin
                e.cmd  = cmd[gidx];
                e.mask = mask[gidx];
                e.dly  = dly[gidx];
                q.push_back(e);
                rr = (gidx + 1) % 2;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        st_valid = 2'b00;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rstn = 1'b0; abort = 1'b0; valid = 2'b00;
        st_rstn = 1'b0; st_abort = 1'b0; st_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cmd[i] = '0; mask[i] = '0; dly[i] = '0;
            set_req(i, 3'd0, 4'h0, 8'd0);
        end

        // reset state
        idle(3);
        st_rstn = 1'b1;

        // single START, dly 0: pulse exactly two cycles after the handshake
        set_req(0, 3'd1, 4'b0101, 8'd0);
        st_valid = 2'b01;
        step();
        st_valid = 2'b00;
        step();
        step();
        chk("t1_start_direct", 32'(t_start), 32'h5);
        idle(3);

        // both requesters continuously valid: alternating grants, FIFO order preserved
        set_req(0, 3'd1, 4'b0001, 8'd0);
        set_req(1, 3'd2, 4'b0010, 8'd0);
        st_valid = 2'b11;
        repeat (12) step();
        idle(14);

        // fill the queue with slow commands: ready drops at 4 entries
        set_req(0, 3'd4, 4'b1111, 8'd3);
        st_valid = 2'b01;
        repeat (20) step();
        idle(30);

        // UPDATE with 5-cycle delay
        set_req(0, 3'd4, 4'b1111, 8'd5);
        st_valid = 2'b01;
        step();
        idle(10);

        // abort while waiting on a queued burst
        set_req(0, 3'd5, 4'b0011, 8'd4);
        st_valid = 2'b01;
        repeat (3) step();
        idle(3);
        st_abort = 1'b1;
        step();
        st_abort = 1'b0;
        idle(8);

        // NOP-coded command interrupted by reset
        set_req(0, 3'd7, 4'b1111, 8'd6);
        st_valid = 2'b01;
        step();
        idle(3);
        st_rstn = 1'b0;
        step();
        st_rstn = 1'b1;
        idle(5);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            st_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++)
                set_req(i, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20))
                                                    : 8'($urandom_range(0, 2)));
            st_abort = ($urandom_range(0, 49) == 0);
            st_rstn  = ($urandom_range(0, 199) != 0);
            step();
        end
        st_abort = 1'b0;
        st_rstn  = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
